acq_sequencer: RTL and testbench

//  Sequences one spectrum frame at a time in the audio/FFT path, on the 100MHz system clock.

---
 rtl/acq_pkg.sv | 15 +
 rtl/acq_timer.sv | 34 +++
 rtl/acq_sequencer.sv | 156 +++++++++++++++
 tb/tb_acq_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// rtl/acq_pkg.sv - shared state encoding and defaults for the acquisition sequencer
package acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_WAIT_FFT = 2'd2,
    ST_HOLDOFF  = 2'd3
  } acq_state_e;

  localparam int ACQ_ADDR_W = 10;
  // Wide enough for multi-second holdoff/timeout values at 100 MHz.
  localparam int ACQ_CNT_W  = 32;

endpackage

// File: rtl/acq_timer.sv
// rtl/acq_timer.sv - loadable down-counter with zero flag, shared by holdoff and timeout
module acq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - frame sequencer: decimated capture into the time buffer, FFT start, wait, holdoff
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int ADDR_W      = ACQ_ADDR_W,
  parameter int HOLDOFF_CYC = 1_000_000,
  parameter int TIMEOUT_CYC = 4_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic              freeze_i,
  input  logic [2:0]        decim_i,
  input  logic              sample_valid_i,
  input  logic              fft_done_i,
  output logic              time_en_o,
  output logic              time_we_o,
  output logic [ADDR_W-1:0] time_addr_o,
  output logic              acq_start_o,
  output logic              busy_o,
  output logic [7:0]        frame_cnt_o,
  output logic              timeout_o
);

  // Timer is loaded with N-1 so that a phase lasts exactly N cycles.
  localparam logic [ACQ_CNT_W-1:0] HOLD_LOAD = ACQ_CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [ACQ_CNT_W-1:0] TMO_LOAD  = ACQ_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = '1;

  acq_state_e        state_q, state_d;
  logic [2:0]        decim_lat_q, decim_lat_d;
  logic [2:0]        decim_cnt_q, decim_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              acq_start_q, acq_start_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              timeout_q, timeout_d;

  logic                 tmr_load, tmr_dec, tmr_zero;
  logic [ACQ_CNT_W-1:0] tmr_val;
  logic                 arm_from_idle, rearm, last_wr, enter_cap;

  assign arm_from_idle = (start_i | continuous_i) & ~freeze_i;
  assign rearm         = continuous_i & ~freeze_i;
  // The final write is visible on the outputs; the frame closes on the following edge.
  assign last_wr       = (state_q == ST_CAPTURE) && we_q && (addr_q == LAST_ADDR);
  assign enter_cap     = (state_q != ST_CAPTURE) && (state_d == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (arm_from_idle) state_d = ST_CAPTURE;
      ST_CAPTURE:  if (last_wr) state_d = ST_WAIT_FFT;
      ST_WAIT_FFT: if (fft_done_i || tmr_zero) state_d = ST_HOLDOFF;
      ST_HOLDOFF:  if (tmr_zero) state_d = rearm ? ST_CAPTURE : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    time_en_o = (state_q == ST_CAPTURE);
    busy_o    = (state_q != ST_IDLE);
  end

  assign tmr_load = ((state_q == ST_CAPTURE) && (state_d == ST_WAIT_FFT)) ||
                    ((state_q == ST_WAIT_FFT) && (state_d == ST_HOLDOFF));
  assign tmr_val  = (state_q == ST_CAPTURE) ? TMO_LOAD : HOLD_LOAD;
  assign tmr_dec  = (state_q == ST_WAIT_FFT) || (state_q == ST_HOLDOFF);

  acq_timer #(.W(ACQ_CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    decim_lat_d = decim_lat_q;
    decim_cnt_d = decim_cnt_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    acq_start_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    timeout_d   = timeout_q;

    if (enter_cap) begin
      decim_lat_d = decim_i;
      decim_cnt_d = '0;
      ptr_d       = '0;
    end

    if ((state_q == ST_CAPTURE) && sample_valid_i && !last_wr) begin
      if (decim_cnt_q == '0) begin
        we_d   = 1'b1;
        addr_d = ptr_q;
        ptr_d  = ptr_q + ADDR_W'(1);
      end
      decim_cnt_d = (decim_cnt_q == decim_lat_q) ? 3'd0 : decim_cnt_q + 3'd1;
    end

    if (last_wr) begin
      acq_start_d = 1'b1;
      addr_d      = '0;
    end

    if (state_q == ST_WAIT_FFT) begin
      if (fft_done_i) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else if (tmr_zero) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      decim_lat_q <= '0;
      decim_cnt_q <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      acq_start_q <= 1'b0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      decim_lat_q <= decim_lat_d;
      decim_cnt_q <= decim_cnt_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      acq_start_q <= acq_start_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign time_we_o   = we_q;
  assign time_addr_o = addr_q;
  assign acq_start_o = acq_start_q;
  assign frame_cnt_o = frame_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - self-checking bench for acq_sequencer with a frame-level reference model
module tb_acq_sequencer;

  localparam int AW   = 4;
  localparam int HOLD = 20;
  localparam int TMO  = 50;
  localparam int NW   = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0, continuous_i = 1'b0, freeze_i = 1'b0;
  logic [2:0]    decim_i = 3'd0;
  logic          sample_valid_i = 1'b0, fft_done_i = 1'b0;
  logic          time_en_o, time_we_o, acq_start_o, busy_o, timeout_o;
  logic [AW-1:0] time_addr_o;
  logic [7:0]    frame_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_frames = 0;
  bit exp_tmo    = 1'b0;

  typedef struct {
    bit start, cont, frz, valid, done;
    bit exp_busy;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  acq_sequencer #(.ADDR_W(AW), .HOLDOFF_CYC(HOLD), .TIMEOUT_CYC(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .continuous_i   (continuous_i),
    .freeze_i       (freeze_i),
    .decim_i        (decim_i),
    .sample_valid_i (sample_valid_i),
    .fft_done_i     (fft_done_i),
    .time_en_o      (time_en_o),
    .time_we_o      (time_we_o),
    .time_addr_o    (time_addr_o),
    .acq_start_o    (acq_start_o),
    .busy_o         (busy_o),
    .frame_cnt_o    (frame_cnt_o),
    .timeout_o      (timeout_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_i = 0; continuous_i = 0; freeze_i = 0; sample_valid_i = 0; fft_done_i = 0;
    step();
    chk("rst_en", time_en_o, 0);     chk("rst_we", time_we_o, 0);
    chk("rst_addr", time_addr_o, 0); chk("rst_start", acq_start_o, 0);
    chk("rst_busy", busy_o, 0);      chk("rst_frames", frame_cnt_o, 0);
    chk("rst_tmo", timeout_o, 0);
    reset = 1'b0;
    exp_frames = 0;
    exp_tmo = 1'b0;
  endtask

  task automatic do_start(input int d);
    decim_i = 3'(d);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1); chk("start_en", time_en_o, 1); chk("start_we", time_we_o, 0);
  endtask

  // Writes land on every (d+1)-th accepted valid, one cycle later, at consecutive addresses.
  task automatic capture_phase(input int d, input int pct, input int stop_after);
    int n = 0, wr = 0, guard = 0;
    bit v, ew, last = 1'b0;
    forever begin
      v = ($urandom_range(99) < pct);
      sample_valid_i = v;
      decim_i = 3'($urandom_range(7));
      step();
      sample_valid_i = 1'b0;
      if (last) begin
        chk("acq_start", acq_start_o, 1); chk("post_cap_en", time_en_o, 0);
        chk("post_cap_we", time_we_o, 0); chk("addr_wrap", time_addr_o, 0);
        break;
      end
      ew = v && ((n % (d + 1)) == 0);
      if (v) n++;
      chk("cap_en", time_en_o, 1); chk("cap_start", acq_start_o, 0); chk("cap_we", time_we_o, ew);
      if (ew) begin
        chk("cap_addr", time_addr_o, wr);
        wr++;
        if (wr == NW) last = 1'b1;
        else if (wr == stop_after) break;
      end
      guard++;
      if (guard > 3000) begin
        chk("cap_guard_expired", 0, 1);
        break;
      end
    end
  endtask

  // Cycle k=0 is the acq_start cycle; done at cycle k wins even on the timeout cycle TMO-1.
  task automatic wait_phase(input int k_done);
    for (int k = 0; k < TMO; k++) begin
      fft_done_i = (k == k_done);
      sample_valid_i = 1'($urandom_range(1));
      start_i = 1'($urandom_range(1));
      step();
      fft_done_i = 0; sample_valid_i = 0; start_i = 0;
      if (k == k_done) begin
        exp_frames++;
        chk("done_frames", frame_cnt_o, exp_frames % 256);
        chk("done_tmo", timeout_o, int'(exp_tmo)); chk("done_busy", busy_o, 1);
        return;
      end
      if (k == TMO - 1) begin
        exp_tmo = 1'b1;
        chk("tmo_flag", timeout_o, 1); chk("tmo_frames", frame_cnt_o, exp_frames % 256);
        chk("tmo_busy", busy_o, 1);
        return;
      end
      chk("wait_en", time_en_o, 0); chk("wait_we", time_we_o, 0); chk("wait_start", acq_start_o, 0);
      chk("wait_tmo", timeout_o, int'(exp_tmo)); chk("wait_busy", busy_o, 1);
    end
  endtask

  task automatic holdoff_phase(input bit recap, input int next_d);
    decim_i = 3'(next_d);
    for (int i = 1; i < HOLD; i++) begin
      start_i = 1'($urandom_range(1));
      step();
      start_i = 1'b0;
      chk("hold_busy", busy_o, 1); chk("hold_en", time_en_o, 0);
      chk("hold_tmo", timeout_o, int'(exp_tmo)); chk("hold_frames", frame_cnt_o, exp_frames % 256);
    end
    start_i = 1'($urandom_range(1));
    step();
    start_i = 1'b0;
    chk("hold_exit_busy", busy_o, int'(recap)); chk("hold_exit_en", time_en_o, int'(recap));
    chk("hold_exit_we", time_we_o, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish (got running, expected finished)");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 1};
    vecs[2] = '{0, 1, 0, 0, 0, 1};
    vecs[3] = '{1, 1, 0, 0, 0, 1};
    vecs[4] = '{1, 0, 1, 0, 0, 0};
    vecs[5] = '{0, 1, 1, 0, 0, 0};
    vecs[6] = '{1, 1, 1, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 0, 0};
    vecs[8] = '{0, 0, 0, 0, 1, 0};

    do_reset();
    do_reset();

    foreach (vecs[i]) begin
      do_reset();
      start_i = vecs[i].start; continuous_i = vecs[i].cont; freeze_i = vecs[i].frz;
      sample_valid_i = vecs[i].valid; fft_done_i = vecs[i].done;
      step();
      start_i = 0; continuous_i = 0; freeze_i = 0; sample_valid_i = 0; fft_done_i = 0;
      chk($sformatf("vec%0d_busy", i), busy_o, int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_en", i), time_en_o, int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_we", i), time_we_o, 0);
    end

    // Back-to-back valids, no decimation, then decimation by 3 with done on the timeout cycle.
    do_reset();
    do_start(0);
    capture_phase(0, 100, NW);
    wait_phase(5);
    holdoff_phase(1'b0, 0);
    do_start(2);
    capture_phase(2, 100, NW);
    wait_phase(TMO - 1);
    holdoff_phase(1'b0, 0);

    // FFT never completes.
    do_reset();
    do_start(0);
    capture_phase(0, 100, NW);
    wait_phase(1000);
    holdoff_phase(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_tmo_idle", busy_o, 0); chk("post_tmo_sticky", timeout_o, 1);
    end

    // Continuous mode, three frames with the holdoff gap between them.
    do_reset();
    continuous_i = 1'b1;
    decim_i = 3'd1;
    step();
    chk("cont_entry_en", time_en_o, 1);
    for (int f = 0; f < 3; f++) begin
      capture_phase(1, 70, NW);
      wait_phase($urandom_range(TMO - 1));
      if (f == 2) continuous_i = 1'b0;
      holdoff_phase(f < 2, 1);
    end
    chk("cont_frames3", frame_cnt_o, 3);

    // Reset mid-capture at address 7, then a clean restart from address 0.
    do_reset();
    do_start(0);
    capture_phase(0, 100, 8);
    chk("pre_rst_addr7", time_addr_o, 7);
    do_reset();
    do_start(0);
    capture_phase(0, 100, NW);
    wait_phase(3);
    holdoff_phase(1'b0, 0);

    // Freeze raised during WAIT_FFT in continuous mode.
    do_reset();
    continuous_i = 1'b1;
    decim_i = 3'd0;
    step();
    chk("frz_entry_en", time_en_o, 1);
    capture_phase(0, 100, NW);
    freeze_i = 1'b1;
    wait_phase(7);
    holdoff_phase(1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frozen_idle", busy_o, 0);
    end
    freeze_i = 1'b0;
    step();
    chk("unfreeze_en", time_en_o, 1);
    continuous_i = 1'b0;
    capture_phase(0, 100, NW);
    wait_phase(2);
    holdoff_phase(1'b0, 0);

    // Randomized single-shot frames.
    do_reset();
    for (int f = 0; f < 10; f++) begin
      int d;
      d = $urandom_range(7);
      do_start(d);
      capture_phase(d, $urandom_range(100, 20), NW);
      wait_phase($urandom_range(TMO + 5));
      holdoff_phase(1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
